nes_poll_ctrl: RTL and testbench
================================

// Module: nes_poll_ctrl
// PURPOSE
//   Sequencer for an NES gamepad inside the TinyQV byte peripheral. Generates the latch and serial
//   clock, samples the active-low serial data, and presents an active-high 8-bit button word to
//   the peripheral register file. Polls on a software start pulse or automatically on a fixed interval.
// PARAMETERS
//   LATCH_CYCLES   768  latch high time in clk cycles (12 us @ 64 MHz); must be >= 1
//   HALF_PERIOD    384  nes_clk half-period in clk cycles (6 us @ 64 MHz); must be >= 1
//   POLL_INTERVAL  16384  idle cycles between automatic polls; must be >= 1
// PORTS
//   clk          in   1  system clock
//   rst          in   1  synchronous, active-high reset
//   start_i      in   1  one-cycle request for a single poll; ignored while busy_o=1
//   auto_en_i    in   1  1 = poll automatically every POLL_INTERVAL idle cycles
//   nes_data_i   in   1  serial data from pad (ui_in[1]); 0 = pressed
//   nes_latch_o  out  1  pad latch (uo_out[6])
//   nes_clk_o    out  1  pad shift clock (uo_out[7])
//   buttons_o    out  8  last completed poll: [0]A [1]B [2]Select [3]Start [4]Up [5]Down [6]Left [7]Right; 1 = pressed
//   valid_o      out  1  one-cycle pulse when buttons_o is updated
//   busy_o       out  1  high from LATCH through DONE inclusive
// BEHAVIOUR
//   - Reset: state IDLE; nes_latch_o=0, nes_clk_o=0, buttons_o=8'h00, valid_o=0, busy_o=0, all counters 0.
//   - States: IDLE -> LATCH -> LOW -> HIGH -> LOW ... -> DONE -> IDLE.
//   - IDLE: latch=0, clk=0. Enter LATCH next cycle if start_i=1, or if auto_en_i=1 and the idle counter
//     reaches POLL_INTERVAL. If both conditions hold in the same cycle, only one poll starts.
//     The idle counter clears on entry to IDLE and holds at 0 while auto_en_i=0.
//   - LATCH: nes_latch_o=1 for exactly LATCH_CYCLES cycles, then enter LOW with bit index 0.
//   - LOW: nes_clk_o=0 for HALF_PERIOD cycles. On the last LOW cycle, sample ~nes_data_i into
//     shift[bit index]. If index=7, enter DONE; otherwise increment the index and enter HIGH.
//   - HIGH: nes_clk_o=1 for HALF_PERIOD cycles, then enter LOW. This produces exactly 7 nes_clk pulses per poll.
//   - DONE: lasts one cycle. buttons_o <= shift, valid_o=1, then enter IDLE.
//     buttons_o changes only in DONE; it never shows a partial word.
//   - busy_o=1 in LATCH, LOW, HIGH and DONE.
//     Poll length is LATCH_CYCLES + 15*HALF_PERIOD + 1 cycles.
//   - Latency: if start_i is seen in IDLE at cycle k, latch rises at k+1 and valid_o pulses at
//     k+1+LATCH_CYCLES+15*HALF_PERIOD.
//   - start_i during busy is dropped (not queued).
//     Clearing auto_en_i mid-poll lets the current poll complete.
//   - All outputs are registered. Phase timer width is $clog2(max(LATCH_CYCLES,HALF_PERIOD))+1;
//     idle counter width is $clog2(POLL_INTERVAL)+1. Neither wraps; each clears on its state exit.
//   - rst mid-poll: the next cycle shows latch=0, clk=0, buttons_o=0, busy_o=0 and no valid_o;
//     the partial shift word is discarded.
// TESTING  (bench params: LATCH_CYCLES=4, HALF_PERIOD=2, POLL_INTERVAL=100; poll length = 35)
//   1. Hold rst 3 cycles, then release -> nes_latch_o, nes_clk_o, busy_o, valid_o = 0; buttons_o=8'h00; stays idle with auto_en_i=0.
//   2. start_i at cycle k; pad model drives bits A..Right = 0,1,1,0,1,1,1,1
//      -> latch high for cycles k+1..k+4; 7 clk pulses; valid_o only at k+35; buttons_o=8'h09.
//   3. Pad data tied 1 -> buttons_o=8'h00. Pad data tied 0 -> buttons_o=8'hFF. Each gives one valid_o per poll.
//   4. start_i pulsed at k, k+10 and k+34 -> exactly one latch pulse and one valid_o.
//      A start_i at k+36 starts a second poll.
//   5. auto_en_i=1 from reset -> first latch rises 101 cycles after rst release;
//      latch rising edges then repeat every 135 cycles. start_i and the auto trigger in the same cycle give a single poll.
//   6. rst asserted while nes_clk_o=1 mid-poll -> next cycle all outputs 0, no valid_o;
//      a subsequent start_i gives a correct full poll.

Source files
------------

// File: rtl/nes_poll_ctrl.sv
// NES gamepad poll sequencer: drives latch and shift clock, samples the active-low serial
// line and publishes an active-high button word after every complete 8-bit read.
module nes_poll_ctrl #(
    parameter int LATCH_CYCLES  = 768,
    parameter int HALF_PERIOD   = 384,
    parameter int POLL_INTERVAL = 16384
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_i,
    input  logic       auto_en_i,
    input  logic       nes_data_i,
    output logic       nes_latch_o,
    output logic       nes_clk_o,
    output logic [7:0] buttons_o,
    output logic       valid_o,
    output logic       busy_o
);

    localparam int PHASE_MAX = (LATCH_CYCLES > HALF_PERIOD) ? LATCH_CYCLES : HALF_PERIOD;
    localparam int PHASE_W   = $clog2(PHASE_MAX) + 1;
    localparam int IDLE_W    = $clog2(POLL_INTERVAL) + 1;

    localparam logic [PHASE_W-1:0] LATCH_LAST = PHASE_W'(LATCH_CYCLES - 1);
    localparam logic [PHASE_W-1:0] HALF_LAST  = PHASE_W'(HALF_PERIOD - 1);
    localparam logic [IDLE_W-1:0]  IDLE_LAST  = IDLE_W'(POLL_INTERVAL - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LATCH = 3'd1,
        LOW   = 3'd2,
        HIGH  = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t              state_reg, state_next;
    logic [PHASE_W-1:0]  phase_reg, phase_next;
    logic [IDLE_W-1:0]   idle_cnt_reg, idle_cnt_next;
    logic [2:0]          bit_idx_reg, bit_idx_next;
    logic [7:0]          shift_reg;
    logic [7:0]          sampled;
    logic                sample_en;
    logic                auto_fire;

    logic                latch_reg;
    logic                sclk_reg;
    logic [7:0]          buttons_reg;
    logic                valid_reg;
    logic                busy_reg;

    assign auto_fire = auto_en_i && (idle_cnt_reg == IDLE_LAST);

    // The word as it will look after this cycle's sample, so the final bit can be
    // published in the same cycle DONE is entered.
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_sample
            assign sampled[gi] = (sample_en && (bit_idx_reg == 3'(gi))) ? ~nes_data_i
                                                                         : shift_reg[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            phase_reg    <= '0;
            idle_cnt_reg <= '0;
            bit_idx_reg  <= '0;
            shift_reg    <= '0;
        end else begin
            state_reg    <= state_next;
            phase_reg    <= phase_next;
            idle_cnt_reg <= idle_cnt_next;
            bit_idx_reg  <= bit_idx_next;
            shift_reg    <= sampled;
        end
    end

    always_comb begin
        state_next    = state_reg;
        phase_next    = phase_reg;
        idle_cnt_next = idle_cnt_reg;
        bit_idx_next  = bit_idx_reg;
        sample_en     = 1'b0;
        case (state_reg)
            IDLE: begin
                phase_next    = '0;
                bit_idx_next  = '0;
                idle_cnt_next = auto_en_i ? (idle_cnt_reg + IDLE_W'(1)) : '0;
                if (start_i || auto_fire) begin
                    state_next    = LATCH;
                    idle_cnt_next = '0;
                end
            end
            LATCH: begin
                if (phase_reg == LATCH_LAST) begin
                    state_next   = LOW;
                    phase_next   = '0;
                    bit_idx_next = '0;
                end else begin
                    phase_next = phase_reg + PHASE_W'(1);
                end
            end
            LOW: begin
                if (phase_reg == HALF_LAST) begin
                    sample_en  = 1'b1;
                    phase_next = '0;
                    if (bit_idx_reg == 3'd7) begin
                        state_next = DONE;
                    end else begin
                        state_next   = HIGH;
                        bit_idx_next = bit_idx_reg + 3'd1;
                    end
                end else begin
                    phase_next = phase_reg + PHASE_W'(1);
                end
            end
            HIGH: begin
                if (phase_reg == HALF_LAST) begin
                    state_next = LOW;
                    phase_next = '0;
                end else begin
                    phase_next = phase_reg + PHASE_W'(1);
                end
            end
            DONE: begin
                state_next    = IDLE;
                phase_next    = '0;
                idle_cnt_next = '0;
            end
            default: begin
                state_next    = IDLE;
                phase_next    = '0;
                idle_cnt_next = '0;
                bit_idx_next  = '0;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge clk) begin
        if (rst) begin
            latch_reg   <= 1'b0;
            sclk_reg    <= 1'b0;
            buttons_reg <= 8'h00;
            valid_reg   <= 1'b0;
            busy_reg    <= 1'b0;
        end else begin
            latch_reg   <= (state_next == LATCH);
            sclk_reg    <= (state_next == HIGH);
            valid_reg   <= (state_next == DONE);
            busy_reg    <= (state_next != IDLE);
            buttons_reg <= (state_next == DONE) ? sampled : buttons_reg;
        end
    end

    assign nes_latch_o = latch_reg;
    assign nes_clk_o   = sclk_reg;
    assign buttons_o   = buttons_reg;
    assign valid_o     = valid_reg;
    assign busy_o      = busy_reg;

endmodule

// File: tb/tb_nes_poll_ctrl.sv
// Directed bench for nes_poll_ctrl with a simple shift-register gamepad model.
module tb_nes_poll_ctrl;

    logic       clk;
    logic       rst;
    logic       start_i;
    logic       auto_en_i;
    logic       nes_data_i;
    logic       nes_latch_o;
    logic       nes_clk_o;
    logic [7:0] buttons_o;
    logic       valid_o;
    logic       busy_o;

    logic [7:0] pad_bits;
    logic [2:0] pad_idx;
    logic       pad_clk_prev;

    int n_checks;
    int n_fail;

    nes_poll_ctrl #(
        .LATCH_CYCLES (4),
        .HALF_PERIOD  (2),
        .POLL_INTERVAL(100)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start_i    (start_i),
        .auto_en_i  (auto_en_i),
        .nes_data_i (nes_data_i),
        .nes_latch_o(nes_latch_o),
        .nes_clk_o  (nes_clk_o),
        .buttons_o  (buttons_o),
        .valid_o    (valid_o),
        .busy_o     (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pad: latch reloads bit 0 (A); each rising shift clock advances to the next button.
    assign nes_data_i = pad_bits[pad_idx];
    always @(posedge clk) begin
        if (nes_latch_o) begin
            pad_idx <= 3'd0;
        end else if (nes_clk_o && !pad_clk_prev && pad_idx != 3'd7) begin
            pad_idx <= pad_idx + 3'd1;
        end
        pad_clk_prev <= nes_clk_o;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
        $display("check %-22s observed %0h expected %0h", tag, obs, exp);
    endtask

    // Issue one start pulse and observe 40 cycles (cycle 1 = first cycle after start_i seen).
    task automatic do_poll(output int lat_first, output int lat_cnt, output int pulses,
                           output int val_cnt, output int val_at, output int busy_cnt,
                           output logic [7:0] word);
        logic pc;
        lat_first = 0; lat_cnt = 0; pulses = 0; val_cnt = 0; val_at = 0; busy_cnt = 0;
        word = 8'h00;
        pc = nes_clk_o;
        start_i = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            tick();
            start_i = 1'b0;
            if (nes_latch_o) begin
                lat_cnt++;
                if (lat_first == 0) lat_first = c;
            end
            if (nes_clk_o && !pc) pulses++;
            pc = nes_clk_o;
            if (valid_o) begin
                val_cnt++;
                val_at = c;
                word = buttons_o;
            end
            if (busy_o) busy_cnt++;
        end
    endtask

    int         lf, lc, cp, vc, va, bc;
    logic [7:0] w;
    int         rises, vcount, second_rise, cyc;
    int         rise_at [4];
    logic       prev_latch;
    logic       found;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst       = 1'b1;
        start_i   = 1'b0;
        auto_en_i = 1'b0;
        pad_bits  = 8'hFF;
        pad_idx   = 3'd0;
        pad_clk_prev = 1'b0;

        // 1: reset state and idling with auto polling off
        repeat (3) tick();
        rst = 1'b0;
        check("reset_latch", 32'(nes_latch_o), 32'd0);
        check("reset_clk", 32'(nes_clk_o), 32'd0);
        check("reset_busy", 32'(busy_o), 32'd0);
        check("reset_valid", 32'(valid_o), 32'd0);
        check("reset_buttons", 32'(buttons_o), 32'h00);
        bc = 0;
        for (int i = 0; i < 120; i++) begin
            tick();
            if (busy_o || nes_latch_o || valid_o) bc++;
        end
        check("idle_no_activity", 32'(bc), 32'd0);

        // 2: A and Start pressed
        pad_bits = 8'b1111_0110;
        do_poll(lf, lc, cp, vc, va, bc, w);
        check("p1_latch_first", 32'(lf), 32'd1);
        check("p1_latch_len", 32'(lc), 32'd4);
        check("p1_clk_pulses", 32'(cp), 32'd7);
        check("p1_valid_cnt", 32'(vc), 32'd1);
        check("p1_valid_at", 32'(va), 32'd35);
        check("p1_busy_len", 32'(bc), 32'd35);
        check("p1_word_at_valid", 32'(w), 32'h09);
        check("p1_buttons_hold", 32'(buttons_o), 32'h09);

        // 3: line idle high = nothing pressed, line low = everything pressed
        pad_bits = 8'hFF;
        do_poll(lf, lc, cp, vc, va, bc, w);
        check("p2_buttons", 32'(buttons_o), 32'h00);
        check("p2_valid_cnt", 32'(vc), 32'd1);
        pad_bits = 8'h00;
        do_poll(lf, lc, cp, vc, va, bc, w);
        check("p3_buttons", 32'(buttons_o), 32'hFF);
        check("p3_valid_cnt", 32'(vc), 32'd1);
        check("p3_valid_at", 32'(va), 32'd35);

        // 4: starts during busy are dropped; one right after DONE is taken
        pad_bits = 8'b1111_0110;
        rises = 0; vcount = 0; second_rise = 0;
        prev_latch = nes_latch_o;
        for (int c = 0; c < 45; c++) begin
            start_i = (c == 0) || (c == 10) || (c == 34) || (c == 36);
            tick();
            cyc = c + 1;
            if (nes_latch_o && !prev_latch) begin
                if (cyc <= 36) rises++;
                else if (second_rise == 0) second_rise = cyc;
            end
            prev_latch = nes_latch_o;
            if (valid_o && cyc <= 36) vcount++;
        end
        start_i = 1'b0;
        check("busy_start_rises", 32'(rises), 32'd1);
        check("busy_start_valids", 32'(vcount), 32'd1);
        check("restart_latch_at", 32'(second_rise), 32'd37);
        repeat (35) tick();
        check("restart_buttons", 32'(buttons_o), 32'h09);

        // 6: reset in the middle of a shift-clock high phase
        pad_bits = 8'h00;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            if (nes_clk_o) found = 1'b1;
            else tick();
        end
        check("mid_reset_clk_seen", 32'(found), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_reset_latch", 32'(nes_latch_o), 32'd0);
        check("mid_reset_clk", 32'(nes_clk_o), 32'd0);
        check("mid_reset_buttons", 32'(buttons_o), 32'h00);
        check("mid_reset_busy", 32'(busy_o), 32'd0);
        check("mid_reset_valid", 32'(valid_o), 32'd0);
        vc = 0; bc = 0;
        for (int i = 0; i < 45; i++) begin
            tick();
            if (valid_o) vc++;
            if (busy_o) bc++;
        end
        check("mid_reset_no_valid", 32'(vc), 32'd0);
        check("mid_reset_no_busy", 32'(bc), 32'd0);
        pad_bits = 8'h55;
        do_poll(lf, lc, cp, vc, va, bc, w);
        check("post_reset_buttons", 32'(buttons_o), 32'hAA);
        check("post_reset_valid_at", 32'(va), 32'd35);
        check("post_reset_pulses", 32'(cp), 32'd7);

        // 5: automatic polling from reset, with a coincident start_i on the third poll
        rst = 1'b1;
        auto_en_i = 1'b1;
        pad_bits = 8'hFF;
        repeat (3) tick();
        rst = 1'b0;
        rises = 0; vcount = 0;
        for (int i = 0; i < 4; i++) rise_at[i] = 0;
        prev_latch = 1'b0;
        for (int c = 1; c < 520; c++) begin
            if (nes_latch_o && !prev_latch) begin
                if (rises < 4) rise_at[rises] = c;
                rises++;
            end
            prev_latch = nes_latch_o;
            if (valid_o && c >= 372 && c <= 505) vcount++;
            start_i = (c == 370);
            tick();
        end
        start_i = 1'b0;
        auto_en_i = 1'b0;
        check("auto_first_rise", 32'(rise_at[0]), 32'd101);
        check("auto_second_rise", 32'(rise_at[1]), 32'd236);
        check("auto_third_rise", 32'(rise_at[2]), 32'd371);
        check("auto_fourth_rise", 32'(rise_at[3]), 32'd506);
        check("auto_rise_count", 32'(rises), 32'd4);
        check("coincident_valids", 32'(vcount), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
